// File: rtl/pipeline_ctrl_if.sv
// Hazard/sequencing bundle between the pipeline datapath and pipeline_ctrl.
// master = controller side, slave = datapath side.
interface pipeline_ctrl_if #(
    parameter int unsigned CNT_W = 32
);
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             id_uses_rs;
    logic             id_uses_rt;
    logic             exe_is_load;
    logic [4:0]       exe_rd;
    logic             exe_branch_taken;
    logic             exe_mdu;
    logic             exe_halt;
    logic             resume;

    logic             pc_go;
    logic             if_id_go;
    logic             if_id_clear;
    logic             id_exe_go;
    logic             id_exe_clear;
    logic             exe_mem_go;
    logic             exe_mem_clear;
    logic             mem_wb_go;
    logic             halted;
    logic [CNT_W-1:0] cycle_cnt;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        input  id_rs, id_rt, id_uses_rs, id_uses_rt, exe_is_load, exe_rd,
               exe_branch_taken, exe_mdu, exe_halt, resume,
        output pc_go, if_id_go, if_id_clear, id_exe_go, id_exe_clear,
               exe_mem_go, exe_mem_clear, mem_wb_go, halted,
               cycle_cnt, stall_cnt, flush_cnt
    );

    modport slave (
        output id_rs, id_rt, id_uses_rs, id_uses_rt, exe_is_load, exe_rd,
               exe_branch_taken, exe_mdu, exe_halt, resume,
        input  pc_go, if_id_go, if_id_clear, id_exe_go, id_exe_clear,
               exe_mem_go, exe_mem_clear, mem_wb_go, halted,
               cycle_cnt, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipeline_ctrl.sv
// 5-stage pipeline hazard controller: load-use stalls, branch flushes, MDU occupancy,
// syscall halt/resume, plus saturating cycle/stall/flush statistics.
module pipeline_ctrl #(
    parameter int unsigned MDU_LAT = 4,
    parameter int unsigned CNT_W   = 32
) (
    input  logic            clk,
    input  logic            rst,
    pipeline_ctrl_if.master bus
);

    localparam int unsigned McntW = (MDU_LAT > 2) ? $clog2(MDU_LAT) : 1;
    localparam logic [McntW-1:0] McntInit = McntW'((MDU_LAT > 1) ? MDU_LAT - 2 : 0);
    localparam bit MduMulti = (MDU_LAT > 1);

    typedef enum logic [1:0] {StRun, StMdu, StHalt} state_e;

    state_e           state_q, state_d;
    logic [McntW-1:0] mcnt_q, mcnt_d;
    logic [CNT_W-1:0] cycle_q, stall_q, flush_q;
    logic             cycle_inc, stall_inc, flush_inc, load_use;
    logic             pc_go, if_id_go, if_id_clear, id_exe_go, id_exe_clear;
    logic             exe_mem_go, exe_mem_clear, mem_wb_go;

    assign load_use = bus.exe_is_load && (bus.exe_rd != 5'd0) &&
                      ((bus.id_uses_rs && (bus.id_rs == bus.exe_rd)) ||
                       (bus.id_uses_rt && (bus.id_rt == bus.exe_rd)));

    always_comb begin
        state_d       = state_q;
        mcnt_d        = mcnt_q;
        cycle_inc     = (state_q != StHalt);
        stall_inc     = 1'b0;
        flush_inc     = 1'b0;
        pc_go         = 1'b1;
        if_id_go      = 1'b1;
        if_id_clear   = 1'b0;
        id_exe_go     = 1'b1;
        id_exe_clear  = 1'b0;
        exe_mem_go    = 1'b1;
        exe_mem_clear = 1'b0;
        mem_wb_go     = 1'b1;
        if (rst) begin
            // Every buffer loads zero while reset is held.
            pc_go         = 1'b0;
            if_id_clear   = 1'b1;
            id_exe_clear  = 1'b1;
            exe_mem_clear = 1'b1;
            cycle_inc     = 1'b0;
        end else begin
            unique case (state_q)
                StRun: begin
                    if (bus.exe_halt) begin
                        pc_go        = 1'b0;
                        if_id_go     = 1'b0;
                        id_exe_clear = 1'b1;
                        state_d      = StHalt;
                    end else if (bus.exe_mdu && MduMulti) begin
                        pc_go         = 1'b0;
                        if_id_go      = 1'b0;
                        id_exe_go     = 1'b0;
                        exe_mem_clear = 1'b1;
                        stall_inc     = 1'b1;
                        state_d       = StMdu;
                        mcnt_d        = McntInit;
                    end else if (bus.exe_branch_taken) begin
                        if_id_clear  = 1'b1;
                        id_exe_clear = 1'b1;
                        flush_inc    = 1'b1;
                    end else if (load_use) begin
                        pc_go        = 1'b0;
                        if_id_go     = 1'b0;
                        id_exe_clear = 1'b1;
                        stall_inc    = 1'b1;
                    end
                end
                StMdu: begin
                    if (mcnt_q != '0) begin
                        pc_go         = 1'b0;
                        if_id_go      = 1'b0;
                        id_exe_go     = 1'b0;
                        exe_mem_clear = 1'b1;
                        stall_inc     = 1'b1;
                        mcnt_d        = mcnt_q - McntW'(1);
                    end else begin
                        state_d = StRun;
                    end
                end
                StHalt: begin
                    pc_go     = 1'b0;
                    if_id_go  = 1'b0;
                    id_exe_go = 1'b0;
                    if (bus.resume) state_d = StRun;
                end
                default: state_d = StRun;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StRun;
            mcnt_q  <= '0;
            cycle_q <= '0;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            state_q <= state_d;
            mcnt_q  <= mcnt_d;
            if (cycle_inc && (cycle_q != '1)) cycle_q <= cycle_q + CNT_W'(1);
            if (stall_inc && (stall_q != '1)) stall_q <= stall_q + CNT_W'(1);
            if (flush_inc && (flush_q != '1)) flush_q <= flush_q + CNT_W'(1);
        end
    end

    assign bus.pc_go         = pc_go;
    assign bus.if_id_go      = if_id_go;
    assign bus.if_id_clear   = if_id_clear;
    assign bus.id_exe_go     = id_exe_go;
    assign bus.id_exe_clear  = id_exe_clear;
    assign bus.exe_mem_go    = exe_mem_go;
    assign bus.exe_mem_clear = exe_mem_clear;
    assign bus.mem_wb_go     = mem_wb_go;
    assign bus.halted        = (state_q == StHalt) && !rst;
    assign bus.cycle_cnt     = cycle_q;
    assign bus.stall_cnt     = stall_q;
    assign bus.flush_cnt     = flush_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench: a wide-counter and a 4-bit-counter controller share stimulus; a
// cycle-level reference model queues expectations that a negedge monitor checks.
module tb_pipeline_ctrl;

    localparam int unsigned Lat = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] id_rs = '0, id_rt = '0, exe_rd = '0;
    logic       id_uses_rs = 0, id_uses_rt = 0, exe_is_load = 0;
    logic       exe_branch_taken = 0, exe_mdu = 0, exe_halt = 0, resume = 0;

    always #5 clk = ~clk;

    pipeline_ctrl_if #(.CNT_W(32)) bus ();
    pipeline_ctrl_if #(.CNT_W(4))  bus4 ();

    assign bus.id_rs = id_rs;                       assign bus4.id_rs = id_rs;
    assign bus.id_rt = id_rt;                       assign bus4.id_rt = id_rt;
    assign bus.id_uses_rs = id_uses_rs;             assign bus4.id_uses_rs = id_uses_rs;
    assign bus.id_uses_rt = id_uses_rt;             assign bus4.id_uses_rt = id_uses_rt;
    assign bus.exe_is_load = exe_is_load;           assign bus4.exe_is_load = exe_is_load;
    assign bus.exe_rd = exe_rd;                     assign bus4.exe_rd = exe_rd;
    assign bus.exe_branch_taken = exe_branch_taken; assign bus4.exe_branch_taken = exe_branch_taken;
    assign bus.exe_mdu = exe_mdu;                   assign bus4.exe_mdu = exe_mdu;
    assign bus.exe_halt = exe_halt;                 assign bus4.exe_halt = exe_halt;
    assign bus.resume = resume;                     assign bus4.resume = resume;

    pipeline_ctrl #(.MDU_LAT(Lat), .CNT_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));
    pipeline_ctrl #(.MDU_LAT(Lat), .CNT_W(4))  dut4 (.clk(clk), .rst(rst), .bus(bus4));

    // ctrl bit order: pc, if_id go/clear, id_exe go/clear, exe_mem go/clear, mem_wb go
    typedef struct {
        logic [7:0] ctrl;
        logic       halted;
        longint     cyc;
        longint     stl;
        longint     fls;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference model: halted flag, remaining EXE cycles of an MDU op, unbounded counters.
    bit     m_halted = 0;
    int     m_busy   = 0;
    longint m_cyc = 0, m_stl = 0, m_fls = 0;

    localparam logic [7:0] PatAdv   = 8'b1101_0101;
    localparam logic [7:0] PatStall = 8'b0001_1101;
    localparam logic [7:0] PatMdu   = 8'b0000_0111;
    localparam logic [7:0] PatFlush = 8'b1111_1101;
    localparam logic [7:0] PatHalt  = 8'b0000_0101;
    localparam logic [7:0] PatReset = 8'b0111_1111;

    function automatic longint sat(input longint v, input int w);
        longint mx = (longint'(1) << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, want);
        end
    endtask

    task automatic model_step(output exp_t e);
        bit lu;
        e.halted = m_halted && !rst;
        e.cyc = m_cyc;
        e.stl = m_stl;
        e.fls = m_fls;
        lu = exe_is_load && exe_rd != 0 &&
             ((id_uses_rs && id_rs == exe_rd) || (id_uses_rt && id_rt == exe_rd));
        if (rst) begin
            e.ctrl = PatReset;
            m_halted = 0; m_busy = 0; m_cyc = 0; m_stl = 0; m_fls = 0;
        end else if (m_halted) begin
            e.ctrl = PatHalt;
            if (resume) m_halted = 0;
        end else begin
            m_cyc++;
            if (m_busy > 0) begin
                e.ctrl = (m_busy > 1) ? PatMdu : PatAdv;
                if (m_busy > 1) m_stl++;
                m_busy--;
            end else if (exe_halt) begin
                e.ctrl = PatStall;
                m_halted = 1;
            end else if (exe_mdu && Lat > 1) begin
                e.ctrl = PatMdu;
                m_stl++;
                m_busy = Lat - 1;
            end else if (exe_branch_taken) begin
                e.ctrl = PatFlush;
                m_fls++;
            end else if (lu) begin
                e.ctrl = PatStall;
                m_stl++;
            end else begin
                e.ctrl = PatAdv;
            end
        end
    endtask

    task automatic step(input bit r, input int rs, input int rt, input bit urs, input bit urt,
                        input bit ld, input int rd, input bit br, input bit mdu,
                        input bit hlt, input bit res);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; id_rs = 5'(rs); id_rt = 5'(rt); id_uses_rs = urs; id_uses_rt = urt;
        exe_is_load = ld; exe_rd = 5'(rd); exe_branch_taken = br; exe_mdu = mdu;
        exe_halt = hlt; resume = res;
        model_step(e);
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    function automatic logic [7:0] ctrl_of(input logic [7:0] v, input logic [7:0] want);
        // clear bits only matter when the matching go is set
        logic [7:0] mask = {1'b1, 1'b1, want[6], 1'b1, want[4], 1'b1, want[2], 1'b1};
        return v & mask;
    endfunction

    initial begin : monitor
        exp_t e;
        logic [7:0] g, g4;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                g  = {bus.pc_go, bus.if_id_go, bus.if_id_clear, bus.id_exe_go,
                      bus.id_exe_clear, bus.exe_mem_go, bus.exe_mem_clear, bus.mem_wb_go};
                g4 = {bus4.pc_go, bus4.if_id_go, bus4.if_id_clear, bus4.id_exe_go,
                      bus4.id_exe_clear, bus4.exe_mem_go, bus4.exe_mem_clear, bus4.mem_wb_go};
                chk("ctrl", 64'(ctrl_of(g, e.ctrl)), 64'(ctrl_of(e.ctrl, e.ctrl)));
                chk("ctrl_w4", 64'(ctrl_of(g4, e.ctrl)), 64'(ctrl_of(e.ctrl, e.ctrl)));
                chk("halted", 64'(bus.halted), 64'(e.halted));
                chk("cycle_cnt", 64'(bus.cycle_cnt), 64'(sat(e.cyc, 32)));
                chk("stall_cnt", 64'(bus.stall_cnt), 64'(sat(e.stl, 32)));
                chk("flush_cnt", 64'(bus.flush_cnt), 64'(sat(e.fls, 32)));
                chk("cycle_cnt_w4", 64'(bus4.cycle_cnt), 64'(sat(e.cyc, 4)));
                chk("stall_cnt_w4", 64'(bus4.stall_cnt), 64'(sat(e.stl, 4)));
                chk("flush_cnt_w4", 64'(bus4.flush_cnt), 64'(sat(e.fls, 4)));
            end
        end
    end

    initial begin : stimulus
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(2);
        // load-use via rt on r5, then the same with exe_rd=0
        step(0, 1, 5, 0, 1, 1, 5, 0, 0, 0, 0);
        idle(1);
        step(0, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0);
        idle(1);
        // taken branch beats a simultaneous load-use
        step(0, 1, 5, 0, 1, 1, 5, 1, 0, 0, 0);
        idle(1);
        // MDU occupies EXE for Lat cycles
        for (int i = 0; i < Lat; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        idle(2);
        // halt with a same-cycle resume (ignored), 10 idle halted cycles, then resume
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        idle(10);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        idle(2);
        // reset while mcnt=1
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(2);
        // 20 consecutive load-use stalls saturate the 4-bit stall counter
        for (int i = 0; i < 20; i++) step(0, 3, 0, 1, 0, 1, 3, 0, 0, 0, 0);
        idle(2);
        // reset while halted
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        idle(3);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(2);
        for (int i = 0; i < 2000; i++) begin
            step(($urandom_range(0, 59) == 0),
                 $urandom_range(0, 3), $urandom_range(0, 3),
                 1'($urandom), 1'($urandom),
                 ($urandom_range(0, 2) == 0), $urandom_range(0, 3),
                 ($urandom_range(0, 4) == 0), ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 19) == 0), ($urandom_range(0, 3) == 0));
        end
        @(negedge clk);
        #1;
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
